// File: rtl/dsp_fetch_sequencer.sv
// Program counter and instruction-fetch sequencer: issues imem requests, tags fetched words
// with their PC, redirects on taken branches and provides run/halt control.
module dsp_fetch_sequencer #(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned RESET_ADDR = 0,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              halt_req,
  input  logic              stall,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  output logic              fetch_valid,
  output logic [ADDR_W-1:0] fetch_pc,
  input  logic              branch_valid,
  input  logic              jump_flag,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic              flush,
  output logic [1:0]        state,
  output logic [CNT_W-1:0]  taken_count
);

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StFetch    = 2'd1,
    StRedirect = 2'd2,
    StHalt     = 2'd3
  } state_e;

  localparam logic [ADDR_W-1:0] ResetPc = ADDR_W'(RESET_ADDR);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               fetch_valid_q, fetch_valid_d;
  logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic               flush_q, flush_d;
  logic [CNT_W-1:0]   taken_count_q, taken_count_d;
  logic               accept;
  logic               taken;

  // Request depends only on registered state and stall, never on imem_ack.
  assign imem_req  = (state_q == StFetch) && !stall;
  assign imem_addr = pc_q;
  assign accept    = imem_req && imem_ack;
  assign taken     = branch_valid && jump_flag && (state_q == StFetch || state_q == StHalt);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    fetch_valid_d = 1'b0;
    fetch_pc_d    = fetch_pc_q;
    flush_d       = 1'b0;
    taken_count_d = taken_count_q;

    if (taken) begin
      pc_d    = jump_addr;
      flush_d = 1'b1;
      if (taken_count_q != {CNT_W{1'b1}}) begin
        taken_count_d = taken_count_q + 1'b1;
      end
    end

    unique case (state_q)
      StIdle: begin
        pc_d = ResetPc;
        if (run) state_d = StFetch;
      end
      StFetch: begin
        if (taken) begin
          // A same-cycle accept is on the wrong path; drop it.
          state_d = halt_req ? StHalt : StRedirect;
        end else begin
          if (accept) begin
            pc_d          = pc_q + 1'b1;
            fetch_valid_d = 1'b1;
            fetch_pc_d    = pc_q;
          end
          if (halt_req) state_d = StHalt;
        end
      end
      StRedirect: state_d = StFetch;
      StHalt: begin
        if (!taken && run && !halt_req) state_d = StFetch;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      pc_q          <= ResetPc;
      fetch_valid_q <= 1'b0;
      fetch_pc_q    <= '0;
      flush_q       <= 1'b0;
      taken_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_pc_q    <= fetch_pc_d;
      flush_q       <= flush_d;
      taken_count_q <= taken_count_d;
    end
  end

  assign fetch_valid = fetch_valid_q;
  assign fetch_pc    = fetch_pc_q;
  assign flush       = flush_q;
  assign state       = state_q;
  assign taken_count = taken_count_q;

endmodule

// File: tb/tb_dsp_fetch_sequencer.sv
// Directed bench for dsp_fetch_sequencer: expected fetch PCs go into a scoreboard queue that a
// negedge monitor drains on fetch_valid; control outputs are checked directly.
module tb_dsp_fetch_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic       halt_req;
  logic       stall;
  logic       imem_req;
  logic [9:0] imem_addr;
  logic       imem_ack;
  logic       fetch_valid;
  logic [9:0] fetch_pc;
  logic       branch_valid;
  logic       jump_flag;
  logic [9:0] jump_addr;
  logic       flush;
  logic [1:0] state;
  logic [15:0] taken_count;

  int unsigned passed = 0;
  int unsigned total  = 0;
  logic [9:0]  exp_q[$];

  always #5 clk = ~clk;

  dsp_fetch_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .run          (run),
    .halt_req     (halt_req),
    .stall        (stall),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .fetch_valid  (fetch_valid),
    .fetch_pc     (fetch_pc),
    .branch_valid (branch_valid),
    .jump_flag    (jump_flag),
    .jump_addr    (jump_addr),
    .flush        (flush),
    .state        (state),
    .taken_count  (taken_count)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic set_branch(input logic v, input logic f, input logic [9:0] a);
    branch_valid = v;
    jump_flag    = f;
    jump_addr    = a;
  endtask

  // Monitor: every presented fetch must match the oldest expected PC.
  always @(negedge clk) begin
    if (!rst && fetch_valid) begin
      if (exp_q.size() == 0) begin
        chk("fetch_unexpected", {22'd0, fetch_pc}, 32'hffff_ffff);
      end else begin
        chk("fetch_pc", {22'd0, fetch_pc}, {22'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    rst = 1'b1; run = 1'b0; halt_req = 1'b0; stall = 1'b0; imem_ack = 1'b0;
    set_branch(1'b0, 1'b0, 10'd0);
    #3;
    chk("rst_state", state, 0);
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_fv", fetch_valid, 0);
    chk("rst_fpc", fetch_pc, 0);
    chk("rst_flush", flush, 0);
    chk("rst_cnt", taken_count, 0);

    // Reset/run: streaming fetch with ack always high.
    next();
    rst = 1'b0; run = 1'b1; imem_ack = 1'b1;
    #3; chk("idle_state", state, 0); chk("idle_req", imem_req, 0);
    next(); run = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #3; chk("run_addr", imem_addr, i); chk("run_req", imem_req, 1);
      exp_q.push_back(10'(i));
      next();
    end

    // Ack backpressure at PC=5.
    imem_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #3; chk("bp_addr", imem_addr, 5);
      if (k > 0) chk("bp_fv", fetch_valid, 0);
      next();
    end
    imem_ack = 1'b1;
    for (int a = 5; a < 8; a++) begin
      #3; chk("bp_resume_addr", imem_addr, a);
      exp_q.push_back(10'(a));
      next();
    end

    // Taken branch at PC=8 with a same-cycle accept.
    set_branch(1'b1, 1'b1, 10'h040);
    #3; chk("br_addr", imem_addr, 8);
    next(); set_branch(1'b0, 1'b0, 10'h0);
    #3;
    chk("br_flush", flush, 1); chk("br_fv", fetch_valid, 0);
    chk("br_state", state, 2); chk("br_req", imem_req, 0); chk("br_cnt", taken_count, 1);
    next();
    #3; chk("tgt_addr", imem_addr, 10'h040); chk("tgt_req", imem_req, 1);
    chk("tgt_state", state, 1); chk("tgt_flush", flush, 0);

    // Not-taken branch: no effect.
    set_branch(1'b1, 1'b0, 10'h200);
    exp_q.push_back(10'h040);
    next(); set_branch(1'b0, 1'b0, 10'h0);
    #3; chk("nt_flush", flush, 0); chk("nt_addr", imem_addr, 10'h041); chk("nt_state", state, 1);

    // Stall and taken branch together: the branch wins.
    stall = 1'b1; set_branch(1'b1, 1'b1, 10'h100);
    #3; chk("sb_req", imem_req, 0);
    next(); stall = 1'b0; set_branch(1'b0, 1'b0, 10'h0);
    #3; chk("sb_flush", flush, 1); chk("sb_state", state, 2); chk("sb_cnt", taken_count, 2);
    next();
    stall = 1'b1;
    #3; chk("st_req", imem_req, 0); chk("st_addr", imem_addr, 10'h100);
    next(); stall = 1'b0;
    #3; chk("st_hold_addr", imem_addr, 10'h100); chk("st_hold_req", imem_req, 1);
    chk("st_fv", fetch_valid, 0);
    exp_q.push_back(10'h100);
    next();

    // Branch to the top address, then halt with an accept there: PC wraps.
    imem_ack = 1'b0; set_branch(1'b1, 1'b1, 10'h3ff);
    next(); set_branch(1'b0, 1'b0, 10'h0); imem_ack = 1'b1;
    next();
    halt_req = 1'b1;
    #3; chk("wrap_addr", imem_addr, 10'h3ff);
    exp_q.push_back(10'h3ff);
    next(); halt_req = 1'b0;
    #3; chk("halt_state", state, 3); chk("halt_req_o", imem_req, 0); chk("halt_addr", imem_addr, 0);
    next(); run = 1'b1;
    next(); run = 1'b0;
    #3; chk("resume_state", state, 1); chk("resume_addr", imem_addr, 0);
    chk("resume_req", imem_req, 1); chk("resume_cnt", taken_count, 3);
    exp_q.push_back(10'h000);
    next();

    // Saturation: taken branches every cycle while halted.
    halt_req = 1'b1; imem_ack = 1'b0;
    next(); halt_req = 1'b0;
    set_branch(1'b1, 1'b1, 10'h02a);
    repeat (65536) @(posedge clk);
    #1;
    chk("sat_cnt", taken_count, 16'hffff); chk("sat_flush", flush, 1);
    chk("sat_state", state, 3); chk("sat_addr", imem_addr, 10'h02a);
    set_branch(1'b0, 1'b0, 10'h0);
    next();
    #3; chk("sat_flush_end", flush, 0); chk("sat_hold_state", state, 3);
    run = 1'b1;
    next(); run = 1'b0;

    // Taken branch together with halt_req: PC redirects, state goes to HALT.
    imem_ack = 1'b1; halt_req = 1'b1; set_branch(1'b1, 1'b1, 10'h055);
    #3; chk("hb_addr", imem_addr, 10'h02a); chk("hb_state", state, 1);
    next(); halt_req = 1'b0; set_branch(1'b0, 1'b0, 10'h0);
    #3; chk("hb_state2", state, 3); chk("hb_flush", flush, 1);
    chk("hb_addr2", imem_addr, 10'h055); chk("hb_fv", fetch_valid, 0);
    run = 1'b1;
    next(); run = 1'b0;

    // Reset mid-request: everything clears immediately.
    #1; chk("mid_addr", imem_addr, 10'h055); chk("mid_req", imem_req, 1);
    rst = 1'b1;
    #1;
    chk("mrst_state", state, 0); chk("mrst_req", imem_req, 0); chk("mrst_addr", imem_addr, 0);
    chk("mrst_fv", fetch_valid, 0); chk("mrst_fpc", fetch_pc, 0);
    chk("mrst_flush", flush, 0); chk("mrst_cnt", taken_count, 0);
    next(); rst = 1'b0; imem_ack = 1'b0;
    next(); next();
    chk("post_rst_fv", fetch_valid, 0); chk("post_rst_state", state, 0);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
